// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes, manager FSM states, command record
// and a response-gating helper reused by managers, subordinates and benches.
package axi_lite_pkg;

   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 64;
   localparam int unsigned AXI_ID_W   = 4;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } mgr_state_t;

   typedef struct packed {
      logic                    write;
      logic [AXI_ID_W-1:0]     id;
      logic [AXI_ADDR_W-1:0]   addr;
      logic [AXI_DATA_W-1:0]   wdata;
      logic [AXI_DATA_W/8-1:0] wstrb;
   } cmd_t;

   // A response whose ID does not match the issued one is reported as SLVERR.
   function automatic logic [1:0] gate_resp(input logic [1:0] resp, input logic id_ok);
      logic [1:0] out_v;
      if (id_ok) begin
         out_v = resp;
      end else begin
         out_v = SLVERR;
      end
      return out_v;
   endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite channel bundle with manager and subordinate views.
interface axi4_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ID_W   = 4
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport manager_mp (
      output awid, awaddr, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input bid, bresp, bvalid, output bready,
      output arid, araddr, arvalid, input arready,
      input rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport subordinate_mp (
      input awid, awaddr, awvalid, output awready,
      input wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input arid, araddr, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi_lite_manager.sv
// Single-outstanding AXI4-Lite manager: cmd/rsp handshake to AXI read/write.
// Optional ID check of BID/RID against the issued ID: define AXI_MGR_IDCHK_EN.
module axi_lite_manager
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ID_W   = 4
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ID_W-1:0]     cmd_id,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_write,
   output logic [ID_W-1:0]     rsp_id,
   output logic [1:0]          rsp_resp,
   output logic [DATA_W-1:0]   rsp_rdata,
`ifdef AXI_MGR_IDCHK_EN
   output logic                id_err,
`endif
   axi4_if.manager_mp          bus_ports
);

   mgr_state_t          state_r, state_n;
   logic [ID_W-1:0]     cmd_id_r, cmd_id_n;
   logic [ADDR_W-1:0]   cmd_addr_r, cmd_addr_n;
   logic [DATA_W-1:0]   cmd_wdata_r, cmd_wdata_n;
   logic [DATA_W/8-1:0] cmd_wstrb_r, cmd_wstrb_n;
   logic                aw_done_r, aw_done_n, w_done_r, w_done_n;
   logic                awvalid_r, awvalid_n, wvalid_r, wvalid_n;
   logic                bready_r, bready_n, arvalid_r, arvalid_n, rready_r, rready_n;
   logic                rsp_valid_r, rsp_valid_n, rsp_write_r, rsp_write_n;
   logic [ID_W-1:0]     rsp_id_r, rsp_id_n;
   logic [1:0]          rsp_resp_r, rsp_resp_n;
   logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_n;
   logic                aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
   logic                b_id_ok_s, r_id_ok_s;

   assign aw_hs_s = awvalid_r & bus_ports.awready;
   assign w_hs_s  = wvalid_r & bus_ports.wready;
   assign b_hs_s  = bready_r & bus_ports.bvalid;
   assign ar_hs_s = arvalid_r & bus_ports.arready;
   assign r_hs_s  = rready_r & bus_ports.rvalid;

`ifdef AXI_MGR_IDCHK_EN
   logic id_err_r, id_err_n;
   assign b_id_ok_s = (bus_ports.bid == cmd_id_r);
   assign r_id_ok_s = (bus_ports.rid == cmd_id_r);
   assign id_err    = id_err_r;
`else
   assign b_id_ok_s = 1'b1;
   assign r_id_ok_s = 1'b1;
`endif

   // Next-state and next-output computation for every registered signal.
   always_comb begin
      state_n     = state_r;
      cmd_id_n    = cmd_id_r;
      cmd_addr_n  = cmd_addr_r;
      cmd_wdata_n = cmd_wdata_r;
      cmd_wstrb_n = cmd_wstrb_r;
      aw_done_n   = aw_done_r;
      w_done_n    = w_done_r;
      awvalid_n   = awvalid_r;
      wvalid_n    = wvalid_r;
      bready_n    = bready_r;
      arvalid_n   = arvalid_r;
      rready_n    = rready_r;
      rsp_valid_n = rsp_valid_r;
      rsp_write_n = rsp_write_r;
      rsp_id_n    = rsp_id_r;
      rsp_resp_n  = rsp_resp_r;
      rsp_rdata_n = rsp_rdata_r;
`ifdef AXI_MGR_IDCHK_EN
      id_err_n    = id_err_r;
`endif
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               cmd_id_n    = cmd_id;
               cmd_addr_n  = cmd_addr;
               cmd_wdata_n = cmd_wdata;
               cmd_wstrb_n = cmd_wstrb;
               if (cmd_write) begin
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  state_n   = WR_REQ;
               end else begin
                  arvalid_n = 1'b1;
                  state_n   = RD_REQ;
               end
            end else begin
               state_n = IDLE;
            end
         end
         WR_REQ: begin
            // AW and W complete independently; each VALID drops after its own handshake.
            awvalid_n = awvalid_r & ~aw_hs_s;
            wvalid_n  = wvalid_r & ~w_hs_s;
            aw_done_n = aw_done_r | aw_hs_s;
            w_done_n  = w_done_r | w_hs_s;
            if (aw_done_n && w_done_n) begin
               aw_done_n = 1'b0;
               w_done_n  = 1'b0;
               bready_n  = 1'b1;
               state_n   = WR_RESP;
            end else begin
               state_n = WR_REQ;
            end
         end
         WR_RESP: begin
            if (b_hs_s) begin
               bready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_write_n = 1'b1;
               rsp_id_n    = bus_ports.bid;
               rsp_resp_n  = gate_resp(bus_ports.bresp, b_id_ok_s);
               rsp_rdata_n = {DATA_W{1'b0}};
`ifdef AXI_MGR_IDCHK_EN
               id_err_n    = id_err_r | ~b_id_ok_s;
`endif
               state_n     = RSP;
            end else begin
               state_n = WR_RESP;
            end
         end
         RD_REQ: begin
            if (ar_hs_s) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = RD_RESP;
            end else begin
               state_n = RD_REQ;
            end
         end
         RD_RESP: begin
            if (r_hs_s) begin
               rready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_write_n = 1'b0;
               rsp_id_n    = bus_ports.rid;
               rsp_resp_n  = gate_resp(bus_ports.rresp, r_id_ok_s);
               rsp_rdata_n = bus_ports.rdata;
`ifdef AXI_MGR_IDCHK_EN
               id_err_n    = id_err_r | ~r_id_ok_s;
`endif
               state_n     = RSP;
            end else begin
               state_n = RD_RESP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               state_n     = IDLE;
            end else begin
               state_n = RSP;
            end
         end
         default: begin
            awvalid_n   = 1'b0;
            wvalid_n    = 1'b0;
            bready_n    = 1'b0;
            arvalid_n   = 1'b0;
            rready_n    = 1'b0;
            rsp_valid_n = 1'b0;
            state_n     = IDLE;
         end
      endcase
   end

   // State and output registers; reset is asynchronous and asserted high.
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         state_r     <= IDLE;
         cmd_id_r    <= {ID_W{1'b0}};
         cmd_addr_r  <= {ADDR_W{1'b0}};
         cmd_wdata_r <= {DATA_W{1'b0}};
         cmd_wstrb_r <= {(DATA_W/8){1'b0}};
         aw_done_r   <= 1'b0;
         w_done_r    <= 1'b0;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_write_r <= 1'b0;
         rsp_id_r    <= {ID_W{1'b0}};
         rsp_resp_r  <= 2'b00;
         rsp_rdata_r <= {DATA_W{1'b0}};
`ifdef AXI_MGR_IDCHK_EN
         id_err_r    <= 1'b0;
`endif
      end else begin
         state_r     <= state_n;
         cmd_id_r    <= cmd_id_n;
         cmd_addr_r  <= cmd_addr_n;
         cmd_wdata_r <= cmd_wdata_n;
         cmd_wstrb_r <= cmd_wstrb_n;
         aw_done_r   <= aw_done_n;
         w_done_r    <= w_done_n;
         awvalid_r   <= awvalid_n;
         wvalid_r    <= wvalid_n;
         bready_r    <= bready_n;
         arvalid_r   <= arvalid_n;
         rready_r    <= rready_n;
         rsp_valid_r <= rsp_valid_n;
         rsp_write_r <= rsp_write_n;
         rsp_id_r    <= rsp_id_n;
         rsp_resp_r  <= rsp_resp_n;
         rsp_rdata_r <= rsp_rdata_n;
`ifdef AXI_MGR_IDCHK_EN
         id_err_r    <= id_err_n;
`endif
      end
   end

   assign cmd_ready = (state_r == IDLE);

   assign rsp_valid = rsp_valid_r;
   assign rsp_write = rsp_write_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_resp  = rsp_resp_r;
   assign rsp_rdata = rsp_rdata_r;

   assign bus_ports.awid    = cmd_id_r;
   assign bus_ports.awaddr  = cmd_addr_r;
   assign bus_ports.awvalid = awvalid_r;
   assign bus_ports.wdata   = cmd_wdata_r;
   assign bus_ports.wstrb   = cmd_wstrb_r;
   assign bus_ports.wlast   = 1'b1;
   assign bus_ports.wvalid  = wvalid_r;
   assign bus_ports.bready  = bready_r;
   assign bus_ports.arid    = cmd_id_r;
   assign bus_ports.araddr  = cmd_addr_r;
   assign bus_ports.arvalid = arvalid_r;
   assign bus_ports.rready  = rready_r;

endmodule

// File: tb/tb_axi_lite_manager.sv
// Scoreboard bench for axi_lite_manager with a behavioural AXI4-Lite memory subordinate.
module tb_axi_lite_manager;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [3:0]  cmd_id = 4'd0;
   logic [31:0] cmd_addr = 32'd0;
   logic [63:0] cmd_wdata = 64'd0;
   logic [7:0]  cmd_wstrb = 8'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_write;
   logic [3:0]  rsp_id;
   logic [1:0]  rsp_resp;
   logic [63:0] rsp_rdata;
`ifdef AXI_MGR_IDCHK_EN
   logic        id_err;
`endif

   axi4_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

   axi_lite_manager #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_id    (cmd_id),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_wstrb (cmd_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_write (rsp_write),
      .rsp_id    (rsp_id),
      .rsp_resp  (rsp_resp),
      .rsp_rdata (rsp_rdata),
`ifdef AXI_MGR_IDCHK_EN
      .id_err    (id_err),
`endif
      .bus_ports (bus.manager_mp)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        w;
      logic [3:0]  id;
      logic [1:0]  resp;
      logic [63:0] rdata;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- subordinate model ----------------
   int          aw_lat = 0;
   int          w_lat = 0;
   logic        force_bid = 1'b0;
   int          aw_hs = 0;
   int          w_hs = 0;
   int          aw_cnt, w_cnt;
   logic        aw_got, w_got;
   logic [31:0] aw_addr_q;
   logic [3:0]  aw_id_q;
   logic [63:0] w_data_q;
   logic [7:0]  w_strb_q;
   logic [63:0] mem [0:511];

   always @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         bus.awready <= 1'b0;
         bus.wready  <= 1'b0;
         bus.bvalid  <= 1'b0;
         bus.bid     <= 4'd0;
         bus.bresp   <= 2'b00;
         bus.arready <= 1'b0;
         bus.rvalid  <= 1'b0;
         bus.rid     <= 4'd0;
         bus.rresp   <= 2'b00;
         bus.rdata   <= 64'd0;
         bus.rlast   <= 1'b1;
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         aw_cnt <= 0;
         w_cnt  <= 0;
         aw_addr_q <= 32'd0;
         aw_id_q   <= 4'd0;
         w_data_q  <= 64'd0;
         w_strb_q  <= 8'd0;
         for (int i = 0; i < 512; i++) mem[i] <= 64'd0;
      end else begin
         if (bus.awvalid && bus.awready) begin
            bus.awready <= 1'b0;
            aw_cnt <= 0;
            aw_got <= 1'b1;
            aw_addr_q <= bus.awaddr;
            aw_id_q <= bus.awid;
            aw_hs <= aw_hs + 1;
         end else if (bus.awvalid && !aw_got && !bus.awready) begin
            if (aw_cnt >= aw_lat) bus.awready <= 1'b1;
            else aw_cnt <= aw_cnt + 1;
         end
         if (bus.wvalid && bus.wready) begin
            bus.wready <= 1'b0;
            w_cnt <= 0;
            w_got <= 1'b1;
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
            w_hs <= w_hs + 1;
         end else if (bus.wvalid && !w_got && !bus.wready) begin
            if (w_cnt >= w_lat) bus.wready <= 1'b1;
            else w_cnt <= w_cnt + 1;
         end
         if (bus.bvalid && bus.bready) begin
            bus.bvalid <= 1'b0;
         end else if (aw_got && w_got && !bus.bvalid) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bus.bvalid <= 1'b1;
            bus.bid <= force_bid ? 4'd5 : aw_id_q;
            if (aw_addr_q < 32'h1000) begin
               bus.bresp <= 2'b00;
               for (int b = 0; b < 8; b++)
                  if (w_strb_q[b]) mem[aw_addr_q[11:3]][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end else begin
               bus.bresp <= 2'b11;
            end
         end
         if (bus.rvalid && bus.rready) begin
            bus.rvalid <= 1'b0;
         end else if (bus.arvalid && bus.arready) begin
            bus.arready <= 1'b0;
            bus.rvalid <= 1'b1;
            bus.rid <= bus.arid;
            if (bus.araddr < 32'h1000) begin
               bus.rdata <= mem[bus.araddr[11:3]];
               bus.rresp <= 2'b00;
            end else begin
               bus.rdata <= 64'd0;
               bus.rresp <= 2'b11;
            end
         end else if (bus.arvalid && !bus.arready && !bus.rvalid) begin
            bus.arready <= 1'b1;
         end
      end
   end

   // ---------------- response monitor ----------------
   always @(negedge ACLK) begin
      if (!ARESETn && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_write", {63'd0, rsp_write}, {63'd0, e.w});
            check("rsp_id", {60'd0, rsp_id}, {60'd0, e.id});
            check("rsp_resp", {62'd0, rsp_resp}, {62'd0, e.resp});
            check("rsp_rdata", rsp_rdata, e.rdata);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic expect_rsp(input logic w, input logic [3:0] id, input logic [1:0] resp, input logic [63:0] rd);
      exp_t e;
      e.w = w; e.id = id; e.resp = resp; e.rdata = rd;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic w, input logic [3:0] id, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] ws);
      bit ok;
      ok = 1'b0;
      @(posedge ACLK); #1;
      cmd_valid = 1'b1; cmd_write = w; cmd_id = id; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
      for (int i = 0; i < 100; i++) begin
         @(negedge ACLK);
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
      if (w) check("awvalid_after_accept", {63'd0, bus.awvalid}, 64'd1);
      else   check("arvalid_after_accept", {63'd0, bus.arvalid}, 64'd1);
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge ACLK);
         if (exp_q.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) check("rsp_timeout", 64'd0, 64'd1);
   endtask

   task automatic pulse_reset();
      @(negedge ACLK);
      ARESETn = 1'b1;
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b0;
   endtask

   int aw0, w0;

   initial begin
      repeat (3) @(negedge ACLK);
      check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_valids", {59'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 64'd0);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_rsp_fields", {rsp_write, rsp_id, rsp_resp}, 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_awaddr", {32'd0, bus.awaddr}, 64'd0);
      check("rst_wdata", bus.wdata, 64'd0);
      check("rst_wstrb_wlast", {55'd0, bus.wstrb, bus.wlast}, 64'd1);
      ARESETn = 1'b0;

      // write then read back
      expect_rsp(1'b1, 4'd1, 2'b00, 64'd0);
      issue(1'b1, 4'd1, 32'h8, 64'hCAFE_BAB0_F00D_FACE, 8'hFF);
      wait_done();
      expect_rsp(1'b0, 4'd4, 2'b00, 64'hCAFE_BAB0_F00D_FACE);
      issue(1'b0, 4'd4, 32'h8, 64'd0, 8'h00);
      wait_done();

      // decode errors at unmapped addresses
      expect_rsp(1'b0, 4'd2, 2'b11, 64'd0);
      issue(1'b0, 4'd2, 32'h0000_2000, 64'd0, 8'h00);
      wait_done();
      expect_rsp(1'b0, 4'd3, 2'b11, 64'd0);
      issue(1'b0, 4'd3, 32'hFFFF_FFF0, 64'd0, 8'h00);
      wait_done();
      @(posedge ACLK); #1;
      check("idle_after_decerr", {63'd0, cmd_ready}, 64'd1);

      // AW/W ordering: W first, AW first, simultaneous
      aw_lat = 3; w_lat = 0;
      aw0 = aw_hs; w0 = w_hs;
      expect_rsp(1'b1, 4'd6, 2'b00, 64'd0);
      issue(1'b1, 4'd6, 32'h20, 64'h1111_2222_3333_4444, 8'hFF);
      wait_done();
      check("aw_hs_wfirst", 64'(aw_hs - aw0), 64'd1);
      check("w_hs_wfirst", 64'(w_hs - w0), 64'd1);
      aw_lat = 0; w_lat = 3;
      aw0 = aw_hs; w0 = w_hs;
      expect_rsp(1'b1, 4'd7, 2'b00, 64'd0);
      issue(1'b1, 4'd7, 32'h28, 64'h0123_4567_89AB_CDEF, 8'hFF);
      wait_done();
      check("aw_hs_awfirst", 64'(aw_hs - aw0), 64'd1);
      check("w_hs_awfirst", 64'(w_hs - w0), 64'd1);
      aw_lat = 2; w_lat = 2;
      aw0 = aw_hs; w0 = w_hs;
      expect_rsp(1'b1, 4'd8, 2'b00, 64'd0);
      issue(1'b1, 4'd8, 32'h30, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
      wait_done();
      check("aw_hs_same", 64'(aw_hs - aw0), 64'd1);
      check("w_hs_same", 64'(w_hs - w0), 64'd1);
      aw_lat = 0; w_lat = 0;
      expect_rsp(1'b0, 4'd9, 2'b00, 64'h0000_0000_AAAA_AAAA);
      issue(1'b0, 4'd9, 32'h30, 64'd0, 8'h00);
      wait_done();

      // response back-pressure
      rsp_ready = 1'b0;
      expect_rsp(1'b0, 4'd5, 2'b00, 64'h0123_4567_89AB_CDEF);
      issue(1'b0, 4'd5, 32'h28, 64'd0, 8'h00);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (rsp_valid) begin seen = 1'b1; break; end
         end
         if (!seen) check("hold_rsp_timeout", 64'd0, 64'd1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
         check("hold_rsp_fields", {57'd0, rsp_write, rsp_id, rsp_resp}, {57'd0, 1'b0, 4'd5, 2'b00});
         check("hold_rsp_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
         check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
         check("hold_no_axi_valid", {61'd0, bus.awvalid, bus.wvalid, bus.arvalid}, 64'd0);
      end
      rsp_ready = 1'b1;
      wait_done();

      // reset while in WR_REQ
      aw_lat = 6; w_lat = 6;
      issue(1'b1, 4'd9, 32'h18, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
      @(negedge ACLK);
      check("wrreq_awvalid", {63'd0, bus.awvalid}, 64'd1);
      ARESETn = 1'b1;
      #1;
      check("midrst_valids", {59'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 64'd0);
      check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b0;
      aw_lat = 0; w_lat = 0;
      expect_rsp(1'b1, 4'd10, 2'b00, 64'd0);
      issue(1'b1, 4'd10, 32'h10, 64'h1122_3344_5566_7788, 8'hFF);
      wait_done();
      expect_rsp(1'b0, 4'd11, 2'b00, 64'h1122_3344_5566_7788);
      issue(1'b0, 4'd11, 32'h10, 64'd0, 8'h00);
      wait_done();

`ifdef AXI_MGR_IDCHK_EN
      force_bid = 1'b1;
      expect_rsp(1'b1, 4'd5, 2'b10, 64'd0);
      issue(1'b1, 4'd2, 32'h40, 64'h5555_6666_7777_8888, 8'hFF);
      wait_done();
      force_bid = 1'b0;
      check("id_err_set", {63'd0, id_err}, 64'd1);
      expect_rsp(1'b1, 4'd3, 2'b00, 64'd0);
      issue(1'b1, 4'd3, 32'h48, 64'h9, 8'hFF);
      wait_done();
      check("id_err_sticky", {63'd0, id_err}, 64'd1);
      pulse_reset();
      @(negedge ACLK);
      check("id_err_cleared", {63'd0, id_err}, 64'd0);
`endif

      repeat (3) @(negedge ACLK);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_lite_manager.md
Name: axi_lite_manager

Overview:
- Single-outstanding AXI4-Lite manager that converts a simple command/response handshake into AXI read or write transactions.
- Sits directly upstream of the memory-mapped subordinate (subordinate2) and drives its axi4_if manager modport.
- Lets firmware-style or sequencer logic, and later a CPU shim, reach register/memory space without hand-driving AXI channels.

Parameters:
- ADDR_W, 32, address width; matches the axi4_if instance.
- DATA_W, 64, data width; WSTRB width is DATA_W/8.
- ID_W, 4, AXI ID width; the command ID is passed through to AWID/ARID.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_id  in  ID_W  transaction ID.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_id  out  ID_W  returned BID/RID.
- rsp_resp  out  2  BRESP/RRESP (or forced error, see feature).
- rsp_rdata  out  DATA_W  RDATA; 0 for writes.
- bus_ports  modport  -  axi4_if.manager_mp (AW, W, B, AR, R channels).

Behaviour:
- Reset (ARESETn=1, asynchronous):
  - state=IDLE.
  - AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid all 0.
  - rsp_id, rsp_resp, rsp_rdata, rsp_write all 0.
  - AWADDR/WDATA/ARADDR and IDs 0; WSTRB 0; WLAST 1 constant.
- Reset mid-transaction drops all VALIDs immediately; no completion is reported.
- All AXI and rsp outputs are registered. cmd_ready = (state==IDLE) combinationally. Only one transaction is outstanding.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - On cmd_valid, latch the command.
  - Write: assert AWVALID and WVALID on the next cycle, go to WR_REQ.
  - Read: assert ARVALID, go to RD_REQ.
- WR_REQ:
  - AW and W handshake independently; aw_done and w_done flags are tracked.
  - Each VALID drops the cycle after its own handshake; VALIDs are never withdrawn before the handshake.
  - AWREADY before WREADY, after it, or in the same cycle are all legal.
  - When both are done: BREADY=1, go to WR_RESP.
- WR_RESP: on BVALID&&BREADY, capture BID/BRESP, BREADY=0, rsp_valid=1, go to RSP.
- RD_REQ: on ARVALID&&ARREADY, ARVALID=0, RREADY=1, go to RD_RESP.
- RD_RESP: on RVALID&&RREADY, capture RID/RRESP/RDATA, RREADY=0, go to RSP. RLAST is ignored (single beat).
- RSP: hold rsp_* stable while rsp_ready=0. On rsp_ready, rsp_valid=0 and return to IDLE. No new command is accepted in that same cycle.
- Minimum latency with zero-wait subordinate and rsp_ready=1:
  - cmd accept to AW/AR valid: 1 cycle.
  - Write: cmd accept to rsp_valid is 4 cycles.
  - Read: cmd accept to rsp_valid is 4 cycles.
- DECERR and SLVERR are reported unchanged; rsp_rdata is passed through as received.

Optional Feature:
- Macro AXI_MGR_IDCHK_EN.
- When defined:
  - A captured BID/RID not equal to the issued ID forces rsp_resp=2'b10.
  - It also sets a sticky output id_err, which clears only on reset.
- When undefined: no check, the id_err port is absent, and the response passes through unchanged.

Decomposition:
- Shared package axi_lite_pkg holds:
  - resp_t enum: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11.
  - The manager FSM state enum.
  - A cmd_t struct (write, id, addr, wdata, wstrb).
- Later subordinates and benches reuse the package.
- No sub-module; a single FSM module is sufficient.

Test Plan:
- Write id=1, 0x8, 0xCAFE_BAB0_F00D_FACE, strb 0xFF, then read id=4 0x8 -> rsp_resp=00, rsp_id=1 then 4, rdata=0xCAFE_BAB0_F00D_FACE.
- Read 0x0000_2000 and 0xFFFF_FFF0 -> rsp_resp=11 for both; FSM returns to IDLE with cmd_ready=1.
- Subordinate asserts WREADY 3 cycles before AWREADY, then the reverse, then both together -> exactly one AW and one W handshake each, one response each.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, no AXI VALID asserted; completion occurs on release.
- Assert ARESETn during WR_REQ with AWVALID=1 -> all VALIDs 0 in the same cycle, no rsp_valid; subsequent write to 0x10 of 0x1122_3344_5566_7788 completes OKAY.
- With AXI_MGR_IDCHK_EN, a stub returns BID=5 for issued ID=2 -> rsp_resp=10, id_err=1 and held until reset.
